// File: rtl/light_pager_if.sv
// Bus between the CPU/top level and the display page controller.
interface light_pager_if;
  logic       key_next;
  logic       auto_en;
  logic [1:0] State;
  logic [7:0] MAR;
  logic [7:0] r0;
  logic [7:0] r1;
  logic [7:0] check_in;
  logic       Z;
  logic [1:0] page;
  logic [7:0] disp_hi;
  logic [7:0] disp_lo;
  logic [3:0] page_led;
  logic       upd;

  modport master (
    output key_next, auto_en, State, MAR, r0, r1, check_in, Z,
    input  page, disp_hi, disp_lo, page_led, upd
  );

  modport slave (
    input  key_next, auto_en, State, MAR, r0, r1, check_in, Z,
    output page, disp_hi, disp_lo, page_led, upd
  );
endinterface

// File: rtl/light_pager.sv
// Display page controller: debounced page key, auto dwell cycling and a forced
// CHECK page while the CPU is in check state; registers the shown values.
module light_pager #(
  parameter int unsigned DEB_CNT = 4,
  parameter int unsigned DWELL   = 16
) (
  input logic         light_clk,
  input logic         rst_n,
  light_pager_if.slave bus
);

  localparam int unsigned DBW = $clog2(DEB_CNT);
  localparam int unsigned DWW = $clog2(DWELL);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEB_CNT - 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);
  localparam logic [1:0]     CPU_CHECK  = 2'b10;
  localparam logic [1:0]     PAGE_CHECK = 2'd2;

  typedef enum logic [1:0] {MANUAL, AUTO, FORCED} state_t;

  logic           sync1, sync2;
  logic           key_lvl, key_lvl_d;
  logic [DBW-1:0] deb_cnt;
  logic           press;

  state_t         state, state_n;
  logic [1:0]     page_q, page_n, page_d;
  logic [1:0]     saved_q, saved_n;
  logic [DWW-1:0] dwell_q, dwell_n;
  logic [7:0]     hi_n, lo_n;

  // Key path: synchronizer, then accept a level only after DEB_CNT differing samples.
  always_ff @(posedge light_clk) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      key_lvl   <= 1'b1;
      key_lvl_d <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      sync1     <= bus.key_next;
      sync2     <= sync1;
      key_lvl_d <= key_lvl;
      if (sync2 != key_lvl) begin
        if (deb_cnt == DEB_LAST) begin
          key_lvl <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DBW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press = key_lvl_d & ~key_lvl;

  always_ff @(posedge light_clk) begin
    if (!rst_n) begin
      state   <= MANUAL;
      page_q  <= '0;
      saved_q <= '0;
      dwell_q <= '0;
    end else begin
      state   <= state_n;
      page_q  <= page_n;
      saved_q <= saved_n;
      dwell_q <= dwell_n;
    end
  end

  always_comb begin
    state_n = state;
    page_n  = page_q;
    saved_n = saved_q;
    dwell_n = dwell_q;
    if (bus.State == CPU_CHECK) begin
      // Check state overrides everything; the page is saved only on entry.
      state_n = FORCED;
      dwell_n = '0;
      if (state != FORCED) begin
        saved_n = page_q;
        page_n  = PAGE_CHECK;
      end
    end else begin
      unique case (state)
        MANUAL: begin
          if (bus.auto_en) begin
            state_n = AUTO;
            dwell_n = '0;
          end
          if (press) page_n = page_q + 2'd1;
        end
        AUTO: begin
          if (!bus.auto_en) begin
            state_n = MANUAL;
            dwell_n = '0;
            if (press) page_n = page_q + 2'd1;
          end else if (press || dwell_q == DWELL_LAST) begin
            page_n  = page_q + 2'd1;
            dwell_n = '0;
          end else begin
            dwell_n = dwell_q + DWW'(1);
          end
        end
        FORCED: begin
          state_n = bus.auto_en ? AUTO : MANUAL;
          page_n  = saved_q;
          dwell_n = '0;
        end
        default: begin
          state_n = MANUAL;
          dwell_n = '0;
        end
      endcase
    end
  end

  always_comb begin
    hi_n = '0;
    lo_n = '0;
    unique case (page_q)
      2'd0: begin hi_n = 8'h00;              lo_n = bus.MAR;           end
      2'd1: begin hi_n = bus.r0;             lo_n = bus.r1;            end
      2'd2: begin hi_n = bus.MAR;            lo_n = bus.check_in;      end
      2'd3: begin hi_n = {6'b0, bus.State};  lo_n = {7'b0, bus.Z};     end
      default: begin hi_n = '0;              lo_n = '0;                end
    endcase
  end

  // Snapshot stage: data, LEDs and the change pulse all move one cycle after page.
  always_ff @(posedge light_clk) begin
    if (!rst_n) begin
      bus.disp_hi  <= '0;
      bus.disp_lo  <= '0;
      bus.page_led <= 4'b0001;
      bus.upd      <= 1'b0;
      page_d       <= '0;
    end else begin
      bus.disp_hi  <= hi_n;
      bus.disp_lo  <= lo_n;
      bus.page_led <= 4'b0001 << page_q;
      bus.upd      <= (page_q != page_d);
      page_d       <= page_q;
    end
  end

  assign bus.page = page_q;

endmodule

// File: tb/tb_light_pager.sv
// Directed self-checking bench for light_pager (DEB_CNT=4, DWELL=16).
module tb_light_pager;
  logic light_clk = 1'b0;
  logic rst_n;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  light_pager_if bus ();

  light_pager #(.DEB_CNT(4), .DWELL(16)) dut (
    .light_clk(light_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 light_clk = ~light_clk;

  task automatic tick();
    @(posedge light_clk);
    #1;
  endtask

  // Full press: low long enough to register, high long enough to settle.
  task automatic press();
    bus.key_next = 1'b0;
    repeat (6) tick();
    bus.key_next = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.key_next = 1'b1; bus.auto_en = 1'b0; bus.State = 2'b00;
    bus.MAR = 8'h5A; bus.r0 = 8'h7F; bus.r1 = 8'h80; bus.check_in = 8'hA5; bus.Z = 1'b0;
    repeat (2) tick();
    chk_cnt++;
    if (bus.page !== 2'd0 || bus.disp_hi !== 8'h00 || bus.disp_lo !== 8'h00 ||
        bus.page_led !== 4'b0001 || bus.upd !== 1'b0)
      $display("FAIL reset_outputs: got page=%0d hi=%h lo=%h led=%b upd=%b want 0 00 00 0001 0",
               bus.page, bus.disp_hi, bus.disp_lo, bus.page_led, bus.upd);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) tick();
    chk_cnt++;
    if (bus.disp_hi !== 8'h00 || bus.disp_lo !== 8'h5A)
      $display("FAIL page0_map: got hi=%h lo=%h want 00 5a", bus.disp_hi, bus.disp_lo);
    else pass_cnt++;
  endtask

  task automatic test_key_latency();
    int upd_n = 0;
    bus.key_next = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.upd) upd_n++;
      if (k == 6) begin
        chk_cnt++;
        if (bus.page !== 2'd0) $display("FAIL key_early: got page=%0d want 0", bus.page);
        else pass_cnt++;
      end
      if (k == 7) begin
        chk_cnt++;
        if (bus.page !== 2'd1) $display("FAIL key_latency: got page=%0d want 1", bus.page);
        else pass_cnt++;
      end
      if (k == 8) begin
        chk_cnt++;
        if (bus.page_led !== 4'b0010 || bus.upd !== 1'b1)
          $display("FAIL key_led_upd: got led=%b upd=%b want 0010 1", bus.page_led, bus.upd);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (upd_n != 1) $display("FAIL key_upd_count: got %0d want 1", upd_n);
    else pass_cnt++;
    bus.key_next = 1'b1;
    repeat (10) tick();
    chk_cnt++;
    if (bus.page !== 2'd1) $display("FAIL key_release: got page=%0d want 1", bus.page);
    else pass_cnt++;
  endtask

  task automatic test_short_pulse();
    int upd_n = 0;
    bus.key_next = 1'b0;
    repeat (3) tick();
    bus.key_next = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.upd) upd_n++;
    end
    chk_cnt++;
    if (bus.page !== 2'd1 || upd_n != 0)
      $display("FAIL short_pulse: got page=%0d upd=%0d want 1 0", bus.page, upd_n);
    else pass_cnt++;
  endtask

  task automatic test_presses_and_map();
    logic [1:0] exp_pg [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      press();
      chk_cnt++;
      if (bus.page !== exp_pg[i])
        $display("FAIL press_seq%0d: got page=%0d want %0d", i, bus.page, exp_pg[i]);
      else pass_cnt++;
      if (i == 1) begin
        bus.State = 2'b01; bus.Z = 1'b1;
        tick();
        chk_cnt++;
        if (bus.disp_hi !== 8'h01 || bus.disp_lo !== 8'h01)
          $display("FAIL flags_map: got hi=%h lo=%h want 01 01", bus.disp_hi, bus.disp_lo);
        else pass_cnt++;
        bus.State = 2'b00; bus.Z = 1'b0;
      end
    end
    tick();
    chk_cnt++;
    if (bus.disp_hi !== 8'h7F || bus.disp_lo !== 8'h80)
      $display("FAIL regs_map: got hi=%h lo=%h want 7f 80", bus.disp_hi, bus.disp_lo);
    else pass_cnt++;
  endtask

  task automatic test_auto();
    bus.auto_en = 1'b1;
    repeat (16) tick();
    chk_cnt++;
    if (bus.page !== 2'd1) $display("FAIL auto_hold: got page=%0d want 1", bus.page);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.page !== 2'd2) $display("FAIL auto_first: got page=%0d want 2", bus.page);
    else pass_cnt++;
    repeat (15) tick();
    chk_cnt++;
    if (bus.page !== 2'd2) $display("FAIL auto_hold2: got page=%0d want 2", bus.page);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.page !== 2'd3) $display("FAIL auto_period: got page=%0d want 3", bus.page);
    else pass_cnt++;
  endtask

  // Press pulse lands on the same edge as the dwell expiry.
  task automatic test_back_to_back();
    repeat (9) tick();
    bus.key_next = 1'b0;
    repeat (6) tick();
    chk_cnt++;
    if (bus.page !== 2'd3) $display("FAIL coincide_pre: got page=%0d want 3", bus.page);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.page !== 2'd0) $display("FAIL coincide_single: got page=%0d want 0", bus.page);
    else pass_cnt++;
    bus.key_next = 1'b1;
    repeat (15) tick();
    chk_cnt++;
    if (bus.page !== 2'd0) $display("FAIL coincide_hold: got page=%0d want 0", bus.page);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.page !== 2'd1) $display("FAIL coincide_next: got page=%0d want 1", bus.page);
    else pass_cnt++;
  endtask

  task automatic test_forced();
    bus.auto_en = 1'b0;
    repeat (3) tick();
    chk_cnt++;
    if (bus.page !== 2'd1) $display("FAIL manual_back: got page=%0d want 1", bus.page);
    else pass_cnt++;
    bus.MAR = 8'h3C; bus.check_in = 8'hA5; bus.State = 2'b10;
    tick();
    chk_cnt++;
    if (bus.page !== 2'd2) $display("FAIL force_page: got page=%0d want 2", bus.page);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.disp_hi !== 8'h3C || bus.disp_lo !== 8'hA5 || bus.upd !== 1'b1 || bus.page_led !== 4'b0100)
      $display("FAIL force_data: got hi=%h lo=%h upd=%b led=%b want 3c a5 1 0100",
               bus.disp_hi, bus.disp_lo, bus.upd, bus.page_led);
    else pass_cnt++;
    press();
    chk_cnt++;
    if (bus.page !== 2'd2) $display("FAIL force_press: got page=%0d want 2", bus.page);
    else pass_cnt++;
    bus.State = 2'b00;
    tick();
    chk_cnt++;
    if (bus.page !== 2'd1) $display("FAIL force_restore: got page=%0d want 1", bus.page);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.upd !== 1'b1 || bus.disp_hi !== 8'h7F)
      $display("FAIL restore_upd: got upd=%b hi=%h want 1 7f", bus.upd, bus.disp_hi);
    else pass_cnt++;
    press();
    bus.State = 2'b10;
    tick();
    tick();
    chk_cnt++;
    if (bus.page !== 2'd2 || bus.upd !== 1'b0)
      $display("FAIL force_from2: got page=%0d upd=%b want 2 0", bus.page, bus.upd);
    else pass_cnt++;
  endtask

  task automatic test_reset_forced();
    int upd_n = 0;
    bus.auto_en = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk_cnt++;
    if (bus.page !== 2'd0 || bus.disp_hi !== 8'h00 || bus.disp_lo !== 8'h00 ||
        bus.page_led !== 4'b0001 || bus.upd !== 1'b0)
      $display("FAIL reset_forced: got page=%0d hi=%h lo=%h led=%b upd=%b want 0 00 00 0001 0",
               bus.page, bus.disp_hi, bus.disp_lo, bus.page_led, bus.upd);
    else pass_cnt++;
    bus.State = 2'b00;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k <= 16 && bus.upd) upd_n++;
      if (k == 16) begin
        chk_cnt++;
        if (bus.page !== 2'd0 || upd_n != 0)
          $display("FAIL post_reset_hold: got page=%0d upd=%0d want 0 0", bus.page, upd_n);
        else pass_cnt++;
      end
      if (k == 17) begin
        chk_cnt++;
        if (bus.page !== 2'd1) $display("FAIL post_reset_auto: got page=%0d want 1", bus.page);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_key_latency();
    test_short_pulse();
    test_presses_and_map();
    test_auto();
    test_back_to_back();
    test_forced();
    test_reset_forced();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
